// File: rtl/hbm_vect_ldst.sv
// hbm_vect_ldst: turns the per-element vector load/store stream into AXI
// AR / AW / W beats, returns read data to the vector RF in issue order and
// back-pressures the auto-increment stage through a combinational stall.
module hbm_vect_ldst #(
  parameter int DEPTH_OUTST   = 8,
  parameter int dwidth_RFadd  = 5,
  parameter int dwidth_HBMadd = 32,
  parameter int dwidth_int    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     elem_valid,
  input  logic                     elem_is_load,
  input  logic [dwidth_HBMadd-1:0] elem_haddr,
  input  logic [dwidth_RFadd-1:0]  elem_rfaddr,
  input  logic [dwidth_int-1:0]    elem_wdata,
  output logic                     stall,
  output logic                     arvalid,
  output logic [dwidth_HBMadd-1:0] araddr,
  input  logic                     arready,
  input  logic                     rvalid,
  input  logic [dwidth_int-1:0]    rdata,
  output logic                     rready,
  output logic                     awvalid,
  output logic [dwidth_HBMadd-1:0] awaddr,
  input  logic                     awready,
  output logic                     wvalid,
  output logic [dwidth_int-1:0]    wdata,
  input  logic                     wready,
  input  logic                     bvalid,
  output logic                     bready,
  output logic                     wen_RF,
  output logic [dwidth_RFadd-1:0]  waddr_RF,
  output logic [dwidth_int-1:0]    wrdata_RF,
  output logic                     idle,
  output logic                     err
);

  localparam int PW = (DEPTH_OUTST > 1) ? $clog2(DEPTH_OUTST) : 1;
  localparam int CW = PW + 1;

  logic [CW-1:0]           load_cnt, store_cnt;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [dwidth_RFadd-1:0] tag_mem [DEPTH_OUTST];

  logic ld_acc, st_acc, r_pop, b_ok;

  // Accept decisions use counts before any same-cycle response, so a full
  // queue only frees a slot on the cycle after the response arrives.
  assign ld_acc = elem_valid & elem_is_load & ~(arvalid & ~arready) &
                  (load_cnt < CW'(DEPTH_OUTST));
  assign st_acc = elem_valid & ~elem_is_load & ~(awvalid & ~awready) &
                  ~(wvalid & ~wready) & (store_cnt < CW'(DEPTH_OUTST));
  assign stall  = elem_valid & ~(ld_acc | st_acc);

  // Responses with nothing outstanding are flagged, never consumed.
  assign r_pop  = rvalid & (load_cnt != '0);
  assign b_ok   = bvalid & (store_cnt != '0);

  assign rready = 1'b1;
  assign bready = 1'b1;
  assign idle   = ~arvalid & ~awvalid & ~wvalid &
                  (load_cnt == '0) & (store_cnt == '0);

  // AR channel: hold address until handshake, reload back-to-back on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid <= 1'b0;
      araddr  <= '0;
    end else if (ld_acc) begin
      arvalid <= 1'b1;
      araddr  <= elem_haddr;
    end else if (arready) begin
      arvalid <= 1'b0;
    end
  end

  // AW and W channels are loaded together but drain independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      awvalid <= 1'b0;
      awaddr  <= '0;
      wvalid  <= 1'b0;
      wdata   <= '0;
    end else if (st_acc) begin
      awvalid <= 1'b1;
      awaddr  <= elem_haddr;
      wvalid  <= 1'b1;
      wdata   <= elem_wdata;
    end else begin
      if (awready) awvalid <= 1'b0;
      if (wready)  wvalid  <= 1'b0;
    end
  end

  // Tag FIFO storage; pointers alone define occupancy so no reset needed.
  always_ff @(posedge clk) begin
    if (ld_acc) tag_mem[wr_ptr] <= elem_rfaddr;
  end

  // Tag FIFO pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (ld_acc) wr_ptr <= wr_ptr + PW'(1);
      if (r_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Outstanding load / store counters; simultaneous inc and dec cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      case ({ld_acc, r_pop})
        2'b10:   load_cnt <= load_cnt + CW'(1);
        2'b01:   load_cnt <= load_cnt - CW'(1);
        default: load_cnt <= load_cnt;
      endcase
      case ({st_acc, b_ok})
        2'b10:   store_cnt <= store_cnt + CW'(1);
        2'b01:   store_cnt <= store_cnt - CW'(1);
        default: store_cnt <= store_cnt;
      endcase
    end
  end

  // RF write-back: one-cycle pulse per R beat, tag taken from FIFO head.
  always_ff @(posedge clk) begin
    if (rst) begin
      wen_RF    <= 1'b0;
      waddr_RF  <= '0;
      wrdata_RF <= '0;
    end else begin
      wen_RF <= r_pop;
      if (r_pop) begin
        waddr_RF  <= tag_mem[rd_ptr];
        wrdata_RF <= rdata;
      end
    end
  end

  // Sticky protocol error for responses without a matching request.
  always_ff @(posedge clk) begin
    if (rst)
      err <= 1'b0;
    else if ((rvalid & ~r_pop) | (bvalid & ~b_ok))
      err <= 1'b1;
  end

endmodule
